// File: rtl/lfsr_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : lfsr_pkg
//  Purpose : Shared definitions for the PRBS generator/checker: checker state
//            encoding, default Galois tap mask for the 32-bit polynomial and a
//            reference Galois step function.
//  Ports   : (package, none)
//  Rev     : 1.0  initial release
// ============================================================================
package lfsr_pkg;

  // Checker state: hunting for alignment, or locked and free-running.
  typedef enum logic [0:0] {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } chk_state_e;

  // x^32 + x^22 + x^2 + x + 1 in right-shifting Galois form.
  localparam logic [31:0] c_default_taps = 32'h0020_0003;

  // Galois step on a state of up to 64 bits; bits at or above width are zero.
  // n[width-1] = fb, n[i] = s[i+1] ^ (taps[i] & fb) below that.
  function automatic logic [63:0] lfsr_step64(input logic [63:0] s,
                                              input logic        fb,
                                              input logic [63:0] taps,
                                              input int unsigned width);
    logic [63:0] n;
    n = '0;
    for (int i = 0; i < 64; i++) begin
      if (i == int'(width) - 1) begin
        n[i] = fb;
      end else if (i < int'(width) - 1) begin
        n[i] = s[i+1] ^ (taps[i] & fb);
      end
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_galois_step.sv
`default_nettype none
// ============================================================================
//  Module  : lfsr_galois_step
//  Purpose : Combinational one-step Galois LFSR update with external feedback
//            bit, so the same block serves a free-running generator and a
//            checker that feeds back received data.
//  Ports   : state_i [WIDTH] current state
//            fb_i    [1]     feedback bit (shifted into the top, XORed at taps)
//            next_o  [WIDTH] next state
//  Rev     : 1.0  initial release
// ============================================================================
module lfsr_galois_step
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(c_default_taps)
) (
  input  logic [WIDTH-1:0] state_i,
  input  logic             fb_i,
  output logic [WIDTH-1:0] next_o
);

  // The LSB is consumed only as the feedback source by the caller.
  logic unused_lsb;
  assign unused_lsb = state_i[0];

  assign next_o[WIDTH-1] = fb_i;

  for (genvar i = 0; i < WIDTH - 1; i++) begin : g_bit
    assign next_o[i] = state_i[i+1] ^ (TAPS[i] & fb_i);
  end

endmodule
`default_nettype wire

// File: rtl/lfsr_prbs_genchk.sv
`default_nettype none
// ============================================================================
//  Module  : lfsr_prbs_genchk
//  Purpose : Galois-LFSR PRBS generator plus self-synchronising checker.
//            Checker hunts for LOCK_CNT consecutive matches using received-bit
//            feedback, then free-runs, counting bit errors per WINDOW and
//            dropping lock when ERR_LIMIT errors land in one window.
//  Ports   : clk_i, rst_i (sync, active high)
//            enable_i, load_i, seed_i[WIDTH], inject_err_i  -> generator
//            tx_bit_o, tx_valid_o                           <- generator
//            rx_bit_i, rx_valid_i, err_clr_i                -> checker
//            locked_o, loss_of_lock_o, err_cnt_o[ERR_W]     <- checker
//  Rev     : 1.0  initial release
// ============================================================================
module lfsr_prbs_genchk
  import lfsr_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] TAPS      = WIDTH'(c_default_taps),
  parameter int               LOCK_CNT  = 64,
  parameter int               WINDOW    = 1024,
  parameter int               ERR_LIMIT = 16,
  parameter int               ERR_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] seed_i,
  input  logic             inject_err_i,
  output logic             tx_bit_o,
  output logic             tx_valid_o,
  input  logic             rx_bit_i,
  input  logic             rx_valid_i,
  input  logic             err_clr_i,
  output logic             locked_o,
  output logic             loss_of_lock_o,
  output logic [ERR_W-1:0] err_cnt_o
);

  localparam int c_match_w = $clog2(LOCK_CNT + 1);
  localparam int c_win_w   = $clog2(WINDOW);
  localparam int c_werr_w  = $clog2(ERR_LIMIT + 1);

  localparam logic [c_match_w-1:0] c_lock_cnt  = c_match_w'(LOCK_CNT);
  localparam logic [c_win_w-1:0]   c_win_last  = c_win_w'(WINDOW - 1);
  localparam logic [c_werr_w-1:0]  c_err_limit = c_werr_w'(ERR_LIMIT);

  // --------------------------------------------------------------------------
  // Generator
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] gen_q, gen_d, gen_step;
  logic             tx_bit_q, tx_bit_d;
  logic             tx_valid_q, tx_valid_d;

  lfsr_galois_step #(.WIDTH(WIDTH), .TAPS(TAPS)) u_gen_step (
    .state_i (gen_q),
    .fb_i    (gen_q[0]),
    .next_o  (gen_step)
  );

  always_comb begin
    gen_d      = gen_q;
    tx_bit_d   = tx_bit_q;
    tx_valid_d = 1'b0;
    if (load_i) begin
      // The all-zero state is a lock-up state for an XOR LFSR.
      gen_d = (seed_i == '0) ? WIDTH'(1) : seed_i;
    end else if (enable_i) begin
      tx_bit_d   = gen_q[0] ^ inject_err_i;
      gen_d      = gen_step;
      tx_valid_d = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Checker
  // --------------------------------------------------------------------------
  chk_state_e          state_q, state_d;
  logic [WIDTH-1:0]    chk_q, chk_d, chk_step;
  logic                chk_fb;
  logic                miss;
  logic                err_hit;
  logic [c_match_w-1:0] match_q, match_d;
  logic [c_win_w-1:0]   win_q, win_d;
  logic [c_werr_w-1:0]  werr_q, werr_d, werr_inc;
  logic [ERR_W-1:0]     err_q, err_d;
  logic                 lol_q, lol_d;

  // While hunting, the received bit drives feedback so any state error is
  // flushed out after WIDTH bits; once locked, the checker free-runs so line
  // errors cannot corrupt its state.
  assign chk_fb = (state_q == ST_HUNT) ? rx_bit_i : chk_q[0];
  assign miss   = chk_q[0] ^ rx_bit_i;

  lfsr_galois_step #(.WIDTH(WIDTH), .TAPS(TAPS)) u_chk_step (
    .state_i (chk_q),
    .fb_i    (chk_fb),
    .next_o  (chk_step)
  );

  always_comb begin
    state_d  = state_q;
    chk_d    = chk_q;
    match_d  = match_q;
    win_d    = win_q;
    werr_d   = werr_q;
    lol_d    = 1'b0;
    err_hit  = 1'b0;
    werr_inc = werr_q + c_werr_w'(miss);
    if (rx_valid_i) begin
      chk_d = chk_step;
      case (state_q)
        ST_HUNT: begin
          match_d = miss ? '0 : match_q + 1'b1;
          if (match_d == c_lock_cnt) begin
            state_d = ST_LOCKED;
            win_d   = '0;
            werr_d  = '0;
          end
        end
        ST_LOCKED: begin
          err_hit = miss;
          if (win_q == c_win_last) begin
            win_d  = '0;
            werr_d = '0;
          end else begin
            win_d  = win_q + 1'b1;
            werr_d = werr_inc;
          end
          // Limit check uses the pre-wrap count so the window-end bit still
          // forces loss of lock.
          if (werr_inc == c_err_limit) begin
            state_d = ST_HUNT;
            match_d = '0;
            lol_d   = 1'b1;
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end
  end

  // Clear wins over increment, but an error in the clearing cycle still counts.
  always_comb begin
    err_d = err_q;
    if (err_clr_i) begin
      err_d = err_hit ? ERR_W'(1) : '0;
    end else if (err_hit && !(&err_q)) begin
      err_d = err_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gen_q      <= WIDTH'(1);
      tx_bit_q   <= 1'b0;
      tx_valid_q <= 1'b0;
      state_q    <= ST_HUNT;
      chk_q      <= WIDTH'(1);
      match_q    <= '0;
      win_q      <= '0;
      werr_q     <= '0;
      err_q      <= '0;
      lol_q      <= 1'b0;
    end else begin
      gen_q      <= gen_d;
      tx_bit_q   <= tx_bit_d;
      tx_valid_q <= tx_valid_d;
      state_q    <= state_d;
      chk_q      <= chk_d;
      match_q    <= match_d;
      win_q      <= win_d;
      werr_q     <= werr_d;
      err_q      <= err_d;
      lol_q      <= lol_d;
    end
  end

  assign tx_bit_o       = tx_bit_q;
  assign tx_valid_o     = tx_valid_q;
  assign locked_o       = (state_q == ST_LOCKED);
  assign loss_of_lock_o = lol_q;
  assign err_cnt_o      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_prbs_genchk.sv
`default_nettype none
// ============================================================================
//  Module  : tb_lfsr_prbs_genchk
//  Purpose : Self-checking bench for lfsr_prbs_genchk against a behavioural
//            reference model, with directed scenarios and a random phase.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_lfsr_prbs_genchk;

  localparam int          LOCK_CNT  = 64;
  localparam int          WINDOW    = 1024;
  localparam int          ERR_LIMIT = 16;
  localparam logic [31:0] POLY32    = 32'h8020_0003;  // fb into bit 31 plus taps
  localparam logic [7:0]  POLY8     = 8'h8E;

  logic        clk = 1'b0;
  logic        rst, enable, load, inject, err_clr, lb, rxb_drv, rxv_drv;
  logic [31:0] seed;
  logic        tx_bit, tx_valid, rx_bit, rx_valid, locked, lol;
  logic [15:0] err_cnt;

  logic        e8_enable, e8_load;
  logic [7:0]  e8_seed;
  logic        tx8_bit, tx8_valid, locked8, lol8;
  logic [7:0]  err8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign rx_bit   = lb ? tx_bit   : rxb_drv;
  assign rx_valid = lb ? tx_valid : rxv_drv;

  lfsr_prbs_genchk dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .load_i(load), .seed_i(seed),
    .inject_err_i(inject), .tx_bit_o(tx_bit), .tx_valid_o(tx_valid),
    .rx_bit_i(rx_bit), .rx_valid_i(rx_valid), .err_clr_i(err_clr),
    .locked_o(locked), .loss_of_lock_o(lol), .err_cnt_o(err_cnt)
  );

  lfsr_prbs_genchk #(.WIDTH(8), .TAPS(8'h8E), .LOCK_CNT(16), .WINDOW(32),
                     .ERR_LIMIT(4), .ERR_W(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .enable_i(e8_enable), .load_i(e8_load),
    .seed_i(e8_seed), .inject_err_i(1'b0), .tx_bit_o(tx8_bit),
    .tx_valid_o(tx8_valid), .rx_bit_i(1'b0), .rx_valid_i(1'b0),
    .err_clr_i(1'b0), .locked_o(locked8), .loss_of_lock_o(lol8),
    .err_cnt_o(err8)
  );

  task automatic check_val(input string tag, input logic [63:0] act,
                           input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_gen, m_chk;
  logic        m_tx, m_txv, m_locked, m_lol;
  int          m_err, m_match, m_win, m_werr;

  function automatic logic [31:0] nxt32(input logic [31:0] s, input logic fb);
    return fb ? ((s >> 1) ^ POLY32) : (s >> 1);
  endfunction

  function automatic logic [7:0] nxt8(input logic [7:0] s);
    return s[0] ? ((s >> 1) ^ POLY8) : (s >> 1);
  endfunction

  task automatic model_tick();
    logic rxb, rxv, miss, hit;
    if (rst) begin
      m_gen = 32'd1; m_chk = 32'd1; m_tx = 1'b0; m_txv = 1'b0;
      m_locked = 1'b0; m_lol = 1'b0;
      m_err = 0; m_match = 0; m_win = 0; m_werr = 0;
    end else begin
      rxb = lb ? m_tx  : rxb_drv;
      rxv = lb ? m_txv : rxv_drv;
      hit = 1'b0;
      m_lol = 1'b0;
      if (load) begin
        m_gen = (seed == 32'd0) ? 32'd1 : seed;
        m_txv = 1'b0;
      end else if (enable) begin
        m_tx  = m_gen[0] ^ inject;
        m_gen = nxt32(m_gen, m_gen[0]);
        m_txv = 1'b1;
      end else begin
        m_txv = 1'b0;
      end
      if (rxv) begin
        miss = (m_chk[0] != rxb);
        if (!m_locked) begin
          m_chk   = nxt32(m_chk, rxb);
          m_match = miss ? 0 : m_match + 1;
          if (m_match == LOCK_CNT) begin
            m_locked = 1'b1; m_win = 0; m_werr = 0;
          end
        end else begin
          m_chk = nxt32(m_chk, m_chk[0]);
          hit   = miss;
          if (miss) m_werr++;
          if (m_werr == ERR_LIMIT) begin
            m_locked = 1'b0; m_match = 0; m_lol = 1'b1; m_win = 0; m_werr = 0;
          end else if (m_win == WINDOW - 1) begin
            m_win = 0; m_werr = 0;
          end else begin
            m_win++;
          end
        end
      end
      if (err_clr)                    m_err = hit ? 1 : 0;
      else if (hit && m_err < 65535)  m_err++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_tick();
    #1;
    check_val("tx_bit",   tx_bit,   m_tx);
    check_val("tx_valid", tx_valid, m_txv);
    check_val("locked",   locked,   m_locked);
    check_val("lol",      lol,      m_lol);
    check_val("err_cnt",  err_cnt,  64'(m_err));
  endtask

  // Align to the start of a fresh error window while locked.
  task automatic wait_window_start();
    tick();
    for (int i = 0; i < 1100 && !(m_locked && m_win == 0); i++) tick();
    check_val("win_align", 64'(m_win), 0);
  endtask

  task automatic wait_lock(input string tag, input int budget);
    for (int i = 0; i < budget && !locked; i++) tick();
    check_val(tag, locked, 1);
  endtask

  initial begin
    logic [7:0] m8;
    int         ones_early, lol_seen, lol_at, lock_at, t;
    logic       locked_at_lol;

    rst = 1'b1; enable = 0; load = 0; inject = 0; err_clr = 0; lb = 0;
    rxb_drv = 0; rxv_drv = 0; seed = '0;
    e8_enable = 0; e8_load = 0; e8_seed = '0;

    // Reset values
    tick(); tick();
    check_val("rst_gen", dut.gen_q, 32'd1);
    check_val("rst_locked", locked, 0);
    rst = 1'b0;

    // 1: load 1, three steps
    load = 1; seed = 32'd1; tick();
    load = 0; enable = 1;
    tick(); check_val("t1_tx0", tx_bit, 1);
    tick(); check_val("t1_tx1", tx_bit, 1);
    check_val("t1_gen2", dut.gen_q, 32'hC030_0002);
    tick(); check_val("t1_tx2", tx_bit, 0);
    enable = 0;

    // 2: 8-bit maximal-length period, zero seed replaced by 1
    e8_load = 1; e8_seed = 8'd0; tick();
    e8_load = 0;
    check_val("t2_seed0", dut8.gen_q, 8'd1);
    m8 = 8'd1; ones_early = 0; e8_enable = 1;
    for (int i = 1; i <= 255; i++) begin
      tick();
      check_val("t2_tx8", tx8_bit, m8[0]);
      m8 = nxt8(m8);
      check_val("t2_gen8", dut8.gen_q, m8);
      if (dut8.gen_q == 8'd0) check_val("t2_nonzero", dut8.gen_q, 8'd1);
      if (i < 255 && dut8.gen_q == 8'd1) ones_early++;
    end
    e8_enable = 0;
    check_val("t2_period", dut8.gen_q, 8'd1);
    check_val("t2_no_short_cycle", 64'(ones_early), 0);

    // 3: scramble checker state with random bits, then loopback and lock
    rxv_drv = 1;
    for (int i = 0; i < 40; i++) begin rxb_drv = 1'($urandom); tick(); end
    rxv_drv = 0; lb = 1;
    load = 1; seed = $urandom | 32'd1; tick();
    load = 0; enable = 1;
    wait_lock("t3_lock", 300);
    check_val("t3_err", err_cnt, 0);

    // 4: three isolated errors, then clear coinciding with a fourth
    for (int k = 0; k < 3; k++) begin
      inject = 1; tick(); inject = 0;
      for (int j = 0; j < 8; j++) tick();
    end
    check_val("t4_err3", err_cnt, 3);
    check_val("t4_locked", locked, 1);
    inject = 1; tick(); inject = 0;
    err_clr = 1; tick(); err_clr = 0;
    check_val("t4_clr_err", err_cnt, 1);

    // 5: ERR_LIMIT errors inside one window -> loss of lock, then relock
    wait_window_start();
    lol_seen = 0; lol_at = -1; lock_at = -1; t = 0; locked_at_lol = 1'b1;
    for (int k = 0; k < 16; k++) begin
      inject = (k < 16);
      for (int j = 0; j < 4; j++) begin
        tick(); inject = 0; t++;
        if (lol) begin lol_seen++; lol_at = t; locked_at_lol = locked; end
      end
    end
    for (int i = 0; i < 200 && lock_at < 0; i++) begin
      tick(); t++;
      if (lol) begin lol_seen++; lol_at = t; end
      if (locked) lock_at = t;
    end
    check_val("t5_lol_once", 64'(lol_seen), 1);
    check_val("t5_unlocked", locked_at_lol, 0);
    check_val("t5_relock_gap", 64'(lock_at - lol_at), 64);

    // Random phase: gaps, sporadic errors, clears and reloads
    for (int i = 0; i < 2000; i++) begin
      enable  = ($urandom_range(0, 9) < 8);
      inject  = enable && ($urandom_range(0, 99) == 0);
      err_clr = ($urandom_range(0, 199) == 0);
      load    = ($urandom_range(0, 499) == 0);
      seed    = $urandom;
      tick();
    end
    load = 0; inject = 0; enable = 1;
    err_clr = 1; tick(); err_clr = 0;

    // 6: reset while locked with five errors counted
    wait_lock("t6_lock", 500);
    wait_window_start();
    for (int k = 0; k < 5; k++) begin
      inject = 1; tick(); inject = 0;
      for (int j = 0; j < 3; j++) tick();
    end
    check_val("t6_err5", err_cnt, 5);
    check_val("t6_locked", locked, 1);
    rst = 1; tick(); rst = 0;
    check_val("t6_rst_locked", locked, 0);
    check_val("t6_rst_err", err_cnt, 0);
    check_val("t6_rst_txv", tx_valid, 0);
    check_val("t6_rst_gen", dut.gen_q, 32'd1);
    for (int i = 0; i < 20; i++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
